// File: rtl/face_scheduler.sv
// Chooses which face the VGA overlay shows. Faces can be picked by switch, auto-cycled, or requested externally.
// Any face change is applied only at a vertical-sync frame boundary.
module face_scheduler #(
    parameter int FRAMES_PER_FACE = 60,
    parameter int MIN_HOLD_FRAMES = 30
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       vga_vs,
    input  logic [1:0] sw_face,
    input  logic       sw_auto,
    input  logic       req_valid,
    input  logic [1:0] req_face,
    output logic       req_ready,
    output logic [1:0] face_select,
    output logic       frame_tick,
    output logic [1:0] mode
);

    localparam int FW = $clog2(FRAMES_PER_FACE + 1);
    localparam int HW = $clog2(MIN_HOLD_FRAMES + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_FACE - 1);
    localparam logic [HW-1:0] HCNT_INIT = HW'(MIN_HOLD_FRAMES);
    localparam logic [HW-1:0] HCNT_LAST = HW'(1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    logic          vs_s1_q, vs_s2_q, vs_prev_q;
    logic [1:0]    swf_s1_q, swf_s2_q;
    logic          swa_s1_q, swa_s2_q;
    logic          tick_q;
    logic          tick_d;
    state_t        state_q;
    logic [1:0]    face_q;
    logic [FW-1:0] fcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          pend_q;
    logic [1:0]    pend_face_q;
    logic          accept_d;

    // vsync idles high, so its synchronizer resets to 1 to avoid a false fall after reset
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_prev_q <= 1'b1;
            swf_s1_q  <= 2'd0;
            swf_s2_q  <= 2'd0;
            swa_s1_q  <= 1'b0;
            swa_s2_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_s1_q   <= vga_vs;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
            swf_s1_q  <= sw_face;
            swf_s2_q  <= swf_s1_q;
            swa_s1_q  <= sw_auto;
            swa_s2_q  <= swa_s1_q;
            tick_q    <= tick_d;
        end
    end

    assign tick_d    = vs_prev_q & ~vs_s2_q;
    assign req_ready = (state_q != HOLD) && !pend_q;
    assign accept_d  = req_valid && req_ready;

    // A request accepted on a tick cycle sets pend_q at that same edge, so it is first seen at the next tick
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= MANUAL;
            face_q      <= 2'd0;
            fcnt_q      <= '0;
            hcnt_q      <= '0;
            pend_q      <= 1'b0;
            pend_face_q <= 2'd0;
        end else begin
            if (accept_d) begin
                pend_q      <= 1'b1;
                pend_face_q <= req_face;
            end
            if (tick_q) begin
                if (pend_q) begin
                    face_q  <= pend_face_q;
                    state_q <= HOLD;
                    hcnt_q  <= HCNT_INIT;
                    pend_q  <= 1'b0;
                end else begin
                    unique case (state_q)
                        MANUAL: begin
                            if (swa_s2_q) begin
                                state_q <= AUTO;
                                fcnt_q  <= '0;
                            end else begin
                                face_q <= swf_s2_q;
                            end
                        end
                        AUTO: begin
                            if (!swa_s2_q) begin
                                state_q <= MANUAL;
                                face_q  <= swf_s2_q;
                            end else if (fcnt_q == FCNT_LAST) begin
                                face_q <= face_q + 2'd1;
                                fcnt_q <= '0;
                            end else begin
                                fcnt_q <= fcnt_q + FW'(1);
                            end
                        end
                        HOLD: begin
                            if (hcnt_q == HCNT_LAST) begin
                                hcnt_q <= '0;
                                if (swa_s2_q) begin
                                    state_q <= AUTO;
                                    fcnt_q  <= '0;
                                end else begin
                                    state_q <= MANUAL;
                                    face_q  <= swf_s2_q;
                                end
                            end else begin
                                hcnt_q <= hcnt_q - HW'(1);
                            end
                        end
                        default: state_q <= MANUAL;
                    endcase
                end
            end
        end
    end

    assign frame_tick  = tick_q;
    assign face_select = face_q;
    assign mode        = state_q;

endmodule
